// File: rtl/debounce_pkg.sv
// Shared definitions for the four-channel switch debouncer.
package debounce_pkg;

  // Per-channel FSM encoding: STABLE means the output agrees with the
  // synchronized input; CHECK means a candidate change is being timed.
  typedef enum logic {
    ST_STABLE = 1'b0,
    ST_CHECK  = 1'b1
  } db_state_t;

  // Default number of en-qualified samples a change must hold.
  localparam int DB_CYCLES_DEFAULT = 16;

endpackage

// File: rtl/switch_debounce4_if.sv
// Signal bundle between the switch front end and the debouncer.
// There is no valid/ready handshake on this bus: raw_in is a free-running
// level sampled every clock, en qualifies which cycles count as debounce
// samples, and A..D/changed/busy are registered levels that are valid in
// every cycle after reset.
interface switch_debounce4_if;
  logic [3:0] raw_in;
  logic       en;
  logic       A;
  logic       B;
  logic       C;
  logic       D;
  logic       changed;
  logic       busy;
  logic [3:0] ch_state;  // debug: 1 = channel in CHECK, bit 3..0 = A..D

  modport master (
    output raw_in, en,
    input  A, B, C, D, changed, busy, ch_state
  );

  modport slave (
    input  raw_in, en,
    output A, B, C, D, changed, busy, ch_state
  );
endinterface

// File: rtl/debounce_ch.sv
// One debounce channel: two-flop synchronizer, STABLE/CHECK FSM and
// sample counter. update is a combinational strobe that is high when the
// output will take a new value on the coming edge.
module debounce_ch
  import debounce_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      raw,
  input  logic      en,
  output logic      level,
  output logic      update,
  output db_state_t state
);

  localparam int CNT_W = $clog2(DB_CYCLES + 1);
  // cnt+1 == DB_CYCLES is the same as cnt == DB_CYCLES-1; comparing against
  // the last count avoids needing an extra carry bit.
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DB_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  db_state_t        state_q;
  db_state_t        state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             level_q;
  logic             level_d;

  // Synchronizer runs every cycle regardless of en.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // FSM, counter and output register; reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_STABLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  // Next-state logic; nothing moves on cycles without en.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    update  = 1'b0;
    if (en) begin
      case (state_q)
        ST_STABLE: begin
          if (sync2 != level_q) begin
            if (DB_CYCLES == 1) begin
              level_d = sync2;
              update  = 1'b1;
            end else begin
              state_d = ST_CHECK;
              cnt_d   = CNT_W'(1);
            end
          end
        end
        ST_CHECK: begin
          if (sync2 == level_q) begin
            // glitch: input went back before the window filled
            state_d = ST_STABLE;
            cnt_d   = '0;
          end else if (cnt_q == LAST) begin
            level_d = sync2;
            cnt_d   = '0;
            state_d = ST_STABLE;
            update  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_STABLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign level = level_q;
  assign state = state_q;

endmodule

// File: rtl/switch_debounce4.sv
// Four debounced switch channels (raw_in bit 3..0 -> A..D) with a shared
// change pulse and busy flag.
module switch_debounce4
  import debounce_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
  input logic                clk,
  input logic                rst,
  switch_debounce4_if.slave  bus
);

  logic [3:0] level;
  logic [3:0] update;
  db_state_t  st [4];
  logic [3:0] in_check;
  logic       changed_q;

  for (genvar gi = 0; gi < 4; gi++) begin : g_ch
    debounce_ch #(
      .DB_CYCLES(DB_CYCLES)
    ) u_ch (
      .clk   (clk),
      .rst   (rst),
      .raw   (bus.raw_in[gi]),
      .en    (bus.en),
      .level (level[gi]),
      .update(update[gi]),
      .state (st[gi])
    );
    assign in_check[gi] = (st[gi] == ST_CHECK);
  end

  // One pulse per update edge, however many channels flip together.
  always_ff @(posedge clk) begin
    if (rst) changed_q <= 1'b0;
    else     changed_q <= |update;
  end

  assign bus.A        = level[3];
  assign bus.B        = level[2];
  assign bus.C        = level[1];
  assign bus.D        = level[0];
  assign bus.changed  = changed_q;
  // State bits are already registers, so busy has no added delay.
  assign bus.busy     = |in_check;
  assign bus.ch_state = in_check;

endmodule

// File: tb/tb_switch_debounce4.sv
// Bench for switch_debounce4: one instance with DB_CYCLES=4 and one with
// DB_CYCLES=1 share the same stimulus.
module tb_switch_debounce4;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] raw = 4'b0000;
  logic       en  = 1'b0;

  always #5 clk = ~clk;

  switch_debounce4_if bus4 ();
  switch_debounce4_if bus1 ();

  assign bus4.raw_in = raw;
  assign bus4.en     = en;
  assign bus1.raw_in = raw;
  assign bus1.en     = en;

  switch_debounce4 #(.DB_CYCLES(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));
  switch_debounce4 #(.DB_CYCLES(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [5:0] exp_q4[$];
  logic [5:0] exp_q1[$];

  function automatic logic [5:0] out4();
    return {bus4.A, bus4.B, bus4.C, bus4.D, bus4.changed, bus4.busy};
  endfunction

  function automatic logic [5:0] out1();
    return {bus1.A, bus1.B, bus1.C, bus1.D, bus1.changed, bus1.busy};
  endfunction

  task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // An output flips once its synchronized input (raw delayed two clocks)
  // has disagreed with it for db consecutive en-cycles; busy means some
  // channel has a partial run in progress.
  int         db [2] = '{4, 1};
  logic [3:0] m_s1 [2];
  logic [3:0] m_s2 [2];
  logic [3:0] m_out [2];
  int         m_run [2][4];
  logic       m_chg [2];
  logic       m_busy [2];

  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_s1[d]  = '0;
        m_s2[d]  = '0;
        m_out[d] = '0;
        m_chg[d] = 1'b0;
        for (int ch = 0; ch < 4; ch++) m_run[d][ch] = 0;
      end else begin
        m_chg[d] = 1'b0;
        if (en) begin
          for (int ch = 0; ch < 4; ch++) begin
            if (m_s2[d][ch] != m_out[d][ch]) begin
              m_run[d][ch] = m_run[d][ch] + 1;
              if (m_run[d][ch] >= db[d]) begin
                m_out[d][ch] = ~m_out[d][ch];
                m_run[d][ch] = 0;
                m_chg[d]     = 1'b1;
              end
            end else begin
              m_run[d][ch] = 0;
            end
          end
        end
        m_s2[d] = m_s1[d];
        m_s1[d] = raw;
      end
      m_busy[d] = 1'b0;
      for (int ch = 0; ch < 4; ch++) if (m_run[d][ch] > 0) m_busy[d] = 1'b1;
    end
    exp_q4.push_back({m_out[0], m_chg[0], m_busy[0]});
    exp_q1.push_back({m_out[1], m_chg[1], m_busy[1]});
  endtask

  // ---------------- driver ----------------
  // Drive on the falling edge, let the rising edge act, sample 1 ns later.
  task automatic step(input logic r, input logic [3:0] rw, input logic e);
    @(negedge clk);
    rst = r;
    raw = rw;
    en  = e;
    @(posedge clk);
    model_step();
    #1;
    check("model_db4", out4(), exp_q4.pop_front());
    check("model_db1", out1(), exp_q1.pop_front());
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       rst;
    logic [3:0] raw;
    logic       en;
    logic [5:0] e4;  // {A,B,C,D,changed,busy} for DB_CYCLES=4
    logic [5:0] e1;  // same for DB_CYCLES=1
  } vec_t;

  vec_t tbl [15];

  logic chg_seen;
  logic busy_seen;
  logic d_seen;
  logic [3:0] flip;

  initial begin
    for (int d = 0; d < 2; d++) begin
      m_s1[d] = '0; m_s2[d] = '0; m_out[d] = '0; m_chg[d] = 1'b0; m_busy[d] = 1'b0;
      for (int ch = 0; ch < 4; ch++) m_run[d][ch] = 0;
    end

    // row i is applied before edge i-1 (row 0 is the reset edge)
    tbl[0]  = '{1'b1, 4'b0000, 1'b1, 6'b000000, 6'b000000};
    tbl[1]  = '{1'b0, 4'b1000, 1'b1, 6'b000000, 6'b000000};  // edge 0
    tbl[2]  = '{1'b0, 4'b1000, 1'b1, 6'b000000, 6'b000000};  // edge 1
    tbl[3]  = '{1'b0, 4'b1000, 1'b1, 6'b000001, 6'b100010};  // edge 2
    tbl[4]  = '{1'b0, 4'b1000, 1'b1, 6'b000001, 6'b100000};  // edge 3
    tbl[5]  = '{1'b0, 4'b1000, 1'b1, 6'b000001, 6'b100000};  // edge 4
    tbl[6]  = '{1'b0, 4'b1000, 1'b1, 6'b100010, 6'b100000};  // edge 5
    tbl[7]  = '{1'b0, 4'b1000, 1'b1, 6'b100000, 6'b100000};  // edge 6
    tbl[8]  = '{1'b0, 4'b1111, 1'b1, 6'b100000, 6'b100000};  // edge 7
    tbl[9]  = '{1'b0, 4'b1111, 1'b1, 6'b100000, 6'b100000};  // edge 8
    tbl[10] = '{1'b0, 4'b1111, 1'b1, 6'b100001, 6'b111110};  // edge 9
    tbl[11] = '{1'b0, 4'b1111, 1'b1, 6'b100001, 6'b111100};  // edge 10
    tbl[12] = '{1'b0, 4'b1111, 1'b1, 6'b100001, 6'b111100};  // edge 11
    tbl[13] = '{1'b0, 4'b1111, 1'b1, 6'b111110, 6'b111100};  // edge 12
    tbl[14] = '{1'b0, 4'b1111, 1'b1, 6'b111100, 6'b111100};  // edge 13

    for (int i = 0; i < 15; i++) begin
      step(tbl[i].rst, tbl[i].raw, tbl[i].en);
      check($sformatf("vec%0d_db4", i), out4(), tbl[i].e4);
      check($sformatf("vec%0d_db1", i), out1(), tbl[i].e1);
    end

    // Two-cycle glitch on D is rejected by DB_CYCLES=4.
    step(1'b1, 4'b0000, 1'b1);
    chg_seen = 1'b0; busy_seen = 1'b0; d_seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, (i < 2) ? 4'b0001 : 4'b0000, 1'b1);
      chg_seen  |= bus4.changed;
      busy_seen |= bus4.busy;
      d_seen    |= bus4.D;
    end
    check("glitch_d_low", 6'(d_seen), 6'd0);
    check("glitch_no_changed", 6'(chg_seen), 6'd0);
    check("glitch_busy_seen", 6'(busy_seen), 6'd1);
    check("glitch_busy_clear", 6'(bus4.busy), 6'd0);

    // en one cycle in three: C needs four qualified samples.
    step(1'b1, 4'b0000, 1'b1);
    for (int i = 0; i <= 12; i++) begin
      step(1'b0, 4'b0010, (i % 3) == 0);
      if (i == 3)  check("slow_en_busy_e3", 6'(bus4.busy), 6'd1);
      if (i == 11) check("slow_en_c_e11", 6'(bus4.C), 6'd0);
      if (i == 12) begin
        check("slow_en_c_e12", 6'(bus4.C), 6'd1);
        check("slow_en_changed_e12", 6'(bus4.changed), 6'd1);
      end
    end

    // Reset in the middle of CHECK on B throws away the count.
    step(1'b1, 4'b0000, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 4'b0100, 1'b1);
    check("midrst_busy_before", 6'(bus4.busy), 6'd1);
    step(1'b1, 4'b0100, 1'b1);
    check("midrst_all_zero_db4", out4(), 6'd0);
    check("midrst_all_zero_db1", out1(), 6'd0);
    for (int i = 5; i <= 10; i++) begin
      step(1'b0, 4'b0100, 1'b1);
      if (i == 9)  check("midrst_b_e9", 6'(bus4.B), 6'd0);
      if (i == 10) check("midrst_b_e10", 6'(bus4.B), 6'd1);
    end

    // DB_CYCLES=1: B follows two edges after the raw change, never busy.
    step(1'b1, 4'b0000, 1'b1);
    busy_seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 4'b0100, 1'b1);
      busy_seen |= bus1.busy;
      if (i == 1) check("db1_b_e1", 6'(bus1.B), 6'd0);
      if (i == 2) check("db1_b_e2", 6'(bus1.B), 6'd1);
    end
    check("db1_never_busy", 6'(busy_seen), 6'd0);

    // Random stimulus against the model.
    step(1'b1, 4'b0000, 1'b1);
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < 4; b++) flip[b] = ($urandom_range(0, 7) == 0);
      step($urandom_range(0, 149) == 0, raw ^ flip, $urandom_range(0, 3) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
